// File: rtl/alarm_siren_controller.sv
// Siren sequencing FSM: exit delay, entry delay, timed alarm and automatic re-arm,
// with a half-second time base. Optional macro ALARM_RETRIGGER_EN lets the sensor extend ALARM.
module alarm_siren_controller #(
    parameter int HALF_SEC_CYCLES = 25_000_000,
    parameter int EXIT_DELAY      = 10,
    parameter int ENTRY_DELAY     = 8,
    parameter int SIREN_TIME      = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm,
    input  logic       disarm,
    input  logic       sensor,
    output logic       enable_siren,
    output logic       two_hz_enable,
    output logic       armed_led,
    output logic [2:0] state,
    output logic [3:0] countdown,
    output logic [3:0] alarm_count
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMING   = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    localparam logic [30:0] HALF_LAST = 31'(HALF_SEC_CYCLES - 1);
    localparam logic [3:0]  EXIT_CNT  = 4'(EXIT_DELAY);
    localparam logic [3:0]  ENTRY_CNT = 4'(ENTRY_DELAY);
    localparam logic [3:0]  SIREN_CNT = 4'(SIREN_TIME);

    state_t      state_q, state_d;
    logic [3:0]  countdown_q, countdown_d;
    logic [3:0]  alarm_count_q, alarm_count_d;
    logic [30:0] presc_q, presc_d;
    logic        phase_q, phase_d;
    logic        blink_q, blink_d;
    logic        half_tick, sec_tick, reload, restart;

    assign half_tick = (presc_q == HALF_LAST);
    assign sec_tick  = half_tick && phase_q;

    // Next state; an expiry replaces the decrement so a timed state never shows 0.
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        alarm_count_d = alarm_count_q;
        reload        = 1'b0;
        if (disarm) begin
            state_d     = S_DISARMED;
            countdown_d = '0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    if (arm) begin
                        state_d     = S_ARMING;
                        countdown_d = EXIT_CNT;
                    end
                end
                S_ARMING: begin
                    if (sec_tick) begin
                        if (countdown_q == 4'd1) begin
                            state_d     = S_ARMED;
                            countdown_d = '0;
                        end else begin
                            countdown_d = countdown_q - 4'd1;
                        end
                    end
                end
                S_ARMED: begin
                    if (sensor) begin
                        state_d     = S_ENTRY;
                        countdown_d = ENTRY_CNT;
                    end
                end
                S_ENTRY: begin
                    if (sec_tick) begin
                        if (countdown_q == 4'd1) begin
                            state_d       = S_ALARM;
                            countdown_d   = SIREN_CNT;
                            alarm_count_d = (alarm_count_q == 4'hF) ? alarm_count_q
                                                                    : alarm_count_q + 4'd1;
                        end else begin
                            countdown_d = countdown_q - 4'd1;
                        end
                    end
                end
                S_ALARM: begin
`ifdef ALARM_RETRIGGER_EN
                    if (sensor) begin
                        countdown_d = SIREN_CNT;
                        reload      = 1'b1;
                    end else
`endif
                    if (sec_tick) begin
                        if (countdown_q == 4'd1) begin
                            state_d     = S_ARMED;
                            countdown_d = '0;
                        end else begin
                            countdown_d = countdown_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d     = S_DISARMED;
                    countdown_d = '0;
                end
            endcase
        end
    end

    // Time base restarts on any state change or reload so residency is exact.
    assign restart = (state_d != state_q) || reload;

    always_comb begin
        presc_d = presc_q + 31'd1;
        phase_d = phase_q;
        blink_d = blink_q;
        if (restart) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (half_tick) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end
        if (state_d == S_ARMING && state_q != S_ARMING) begin
            blink_d = 1'b1;
        end else if (state_q == S_ARMING && half_tick) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_DISARMED;
            countdown_q   <= '0;
            alarm_count_q <= '0;
            presc_q       <= '0;
            phase_q       <= 1'b0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            alarm_count_q <= alarm_count_d;
            presc_q       <= presc_d;
            phase_q       <= phase_d;
            blink_q       <= blink_d;
        end
    end

    assign state         = state_q;
    assign countdown     = countdown_q;
    assign alarm_count   = alarm_count_q;
    assign enable_siren  = (state_q == S_ALARM);
    assign two_hz_enable = half_tick && (state_q == S_ALARM);
    assign armed_led     = (state_q == S_ARMING) ? blink_q
                         : ((state_q == S_ARMED) || (state_q == S_ENTRY) || (state_q == S_ALARM));

endmodule

// File: tb/tb_alarm_siren_controller.sv
// Directed bench for alarm_siren_controller with HALF_SEC_CYCLES=4, EXIT=2, ENTRY=3, SIREN=4.
module tb_alarm_siren_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       sensor = 1'b0;
    logic       enable_siren, two_hz_enable, armed_led;
    logic [2:0] state;
    logic [3:0] countdown, alarm_count;
    int         total = 0;
    int         bad = 0;

    alarm_siren_controller #(
        .HALF_SEC_CYCLES(4),
        .EXIT_DELAY     (2),
        .ENTRY_DELAY    (3),
        .SIREN_TIME     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .disarm       (disarm),
        .sensor       (sensor),
        .enable_siren (enable_siren),
        .two_hz_enable(two_hz_enable),
        .armed_led    (armed_led),
        .state        (state),
        .countdown    (countdown),
        .alarm_count  (alarm_count)
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs set after this are sampled at the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alarm_from_armed();
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        repeat (24) tick();
    endtask

    task automatic go_to_alarm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (16) tick();
        alarm_from_armed();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if (state !== 3'd0 || countdown !== 4'd0 || alarm_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_regs: state=%0d countdown=%0d alarm_count=%0d want 0/0/0",
                     state, countdown, alarm_count);
        end
        total++;
        if (enable_siren !== 1'b0 || two_hz_enable !== 1'b0 || armed_led !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: siren=%b two_hz=%b led=%b want 0/0/0",
                     enable_siren, two_hz_enable, armed_led);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_arming();
        logic exp_led;
        logic [3:0] exp_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total++;
        if (state !== 3'd1 || countdown !== 4'd2 || armed_led !== 1'b1) begin
            bad++;
            $display("FAIL arm_entry: state=%0d countdown=%0d led=%b want 1/2/1",
                     state, countdown, armed_led);
        end
        for (int j = 1; j < 16; j++) begin
            tick();
            exp_led = ((j / 4) % 2 == 0);
            exp_cnt = (j < 8) ? 4'd2 : 4'd1;
            total++;
            if (state !== 3'd1 || countdown !== exp_cnt || armed_led !== exp_led) begin
                bad++;
                $display("FAIL arming_cycle%0d: state=%0d countdown=%0d led=%b want 1/%0d/%b",
                         j, state, countdown, armed_led, exp_cnt, exp_led);
            end
        end
        tick();
        total++;
        if (state !== 3'd2 || countdown !== 4'd0 || armed_led !== 1'b1) begin
            bad++;
            $display("FAIL armed_at16: state=%0d countdown=%0d led=%b want 2/0/1",
                     state, countdown, armed_led);
        end
    endtask

    task automatic test_entry_disarm();
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        total++;
        if (state !== 3'd3 || countdown !== 4'd3) begin
            bad++;
            $display("FAIL entry_start: state=%0d countdown=%0d want 3/3", state, countdown);
        end
        for (int j = 1; j <= 10; j++) begin
            tick();
            total++;
            if (state !== 3'd3 || enable_siren !== 1'b0) begin
                bad++;
                $display("FAIL entry_cycle%0d: state=%0d siren=%b want 3/0",
                         j, state, enable_siren);
            end
        end
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        total++;
        if (state !== 3'd0 || countdown !== 4'd0 || alarm_count !== 4'd0 || armed_led !== 1'b0
            || enable_siren !== 1'b0) begin
            bad++;
            $display("FAIL entry_disarm: state=%0d cnt=%0d acnt=%0d led=%b siren=%b want 0/0/0/0/0",
                     state, countdown, alarm_count, armed_led, enable_siren);
        end
    endtask

    task automatic test_alarm();
        int pulses;
        logic exp_pulse;
        logic [3:0] exp_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (16) tick();
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        repeat (23) tick();
        total++;
        if (state !== 3'd3 || countdown !== 4'd1) begin
            bad++;
            $display("FAIL entry_at23: state=%0d countdown=%0d want 3/1", state, countdown);
        end
        tick();
        total++;
        if (state !== 3'd4 || enable_siren !== 1'b1 || alarm_count !== 4'd1 || countdown !== 4'd4) begin
            bad++;
            $display("FAIL alarm_start: state=%0d siren=%b acnt=%0d cnt=%0d want 4/1/1/4",
                     state, enable_siren, alarm_count, countdown);
        end
        pulses = 0;
        for (int a = 0; a < 32; a++) begin
            if (a > 0) tick();
            exp_pulse = (a % 4 == 3);
            exp_cnt = 4'(4 - a / 8);
            if (two_hz_enable === 1'b1) pulses++;
            total++;
            if (state !== 3'd4 || two_hz_enable !== exp_pulse || countdown !== exp_cnt) begin
                bad++;
                $display("FAIL alarm_cycle%0d: state=%0d two_hz=%b cnt=%0d want 4/%b/%0d",
                         a, state, two_hz_enable, countdown, exp_pulse, exp_cnt);
            end
        end
        total++;
        if (pulses != 8) begin
            bad++;
            $display("FAIL two_hz_count: got %0d want 8", pulses);
        end
        tick();
        total++;
        if (state !== 3'd2 || enable_siren !== 1'b0 || countdown !== 4'd0 || alarm_count !== 4'd1) begin
            bad++;
            $display("FAIL alarm_end: state=%0d siren=%b cnt=%0d acnt=%0d want 2/0/0/1",
                     state, enable_siren, countdown, alarm_count);
        end
    endtask

    task automatic test_arm_disarm_together();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL disarm_from_armed: state=%0d want 0", state);
        end
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        arm = 1'b0;
        disarm = 1'b0;
        total++;
        if (state !== 3'd0 || countdown !== 4'd0 || armed_led !== 1'b0) begin
            bad++;
            $display("FAIL arm_disarm_same: state=%0d cnt=%0d led=%b want 0/0/0",
                     state, countdown, armed_led);
        end
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL arm_disarm_after: state=%0d want 0", state);
        end
    endtask

    task automatic test_reset_mid_alarm();
        go_to_alarm();
        repeat (5) tick();
        total++;
        if (state !== 3'd4 || alarm_count !== 4'd2) begin
            bad++;
            $display("FAIL pre_reset_alarm: state=%0d acnt=%0d want 4/2", state, alarm_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (state !== 3'd0 || countdown !== 4'd0 || alarm_count !== 4'd0 || enable_siren !== 1'b0
            || two_hz_enable !== 1'b0 || armed_led !== 1'b0) begin
            bad++;
            $display("FAIL mid_alarm_reset: state=%0d cnt=%0d acnt=%0d siren=%b two_hz=%b led=%b want all 0",
                     state, countdown, alarm_count, enable_siren, two_hz_enable, armed_led);
        end
    endtask

    task automatic test_retrigger();
        int res;
        int exp_res;
        logic [3:0] exp_cnt;
`ifdef ALARM_RETRIGGER_EN
        exp_cnt = 4'd4;
        exp_res = 52;
`else
        exp_cnt = 4'd2;
        exp_res = 32;
`endif
        go_to_alarm();
        total++;
        if (state !== 3'd4) begin
            bad++;
            $display("FAIL retrig_start: state=%0d want 4", state);
        end
        repeat (19) tick();
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        total++;
        if (state !== 3'd4 || countdown !== exp_cnt) begin
            bad++;
            $display("FAIL retrig_cnt: state=%0d cnt=%0d want 4/%0d", state, countdown, exp_cnt);
        end
        res = 20;
        while (state === 3'd4 && res < 80) begin
            tick();
            res++;
        end
        total++;
        if (res != exp_res || state !== 3'd2 || alarm_count !== 4'd1) begin
            bad++;
            $display("FAIL retrig_len: cycles=%0d state=%0d acnt=%0d want %0d/2/1",
                     res, state, alarm_count, exp_res);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_acnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin
            alarm_from_armed();
            exp_acnt = (i >= 14) ? 4'd15 : 4'(i + 1);
            repeat (32) tick();
            total++;
            if (state !== 3'd2 || alarm_count !== exp_acnt) begin
                bad++;
                $display("FAIL sat_round%0d: state=%0d acnt=%0d want 2/%0d",
                         i, state, alarm_count, exp_acnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_entry_disarm();
        test_alarm();
        test_arm_disarm_together();
        test_reset_mid_alarm();
        test_retrigger();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
